// File: rtl/pipe4p_pkg.sv
`timescale 1ns/1ps
// Shared constants for the pipe4p four-stage ALU pipeline: default sizes and opcodes.
package pipe4p_pkg;

    localparam int DW_DEF   = 16;
    localparam int NREG_DEF = 16;
    localparam int AW_DEF   = 8;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_MOD = 4'd4;
    localparam logic [3:0] OP_AND = 4'd5;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_XOR = 4'd7;

endpackage

// File: rtl/pipe4p_alu_core.sv
`timescale 1ns/1ps
// Combinational ALU for the pipe4p pipeline. Results wrap to DW bits; divide/modulo
// by zero and unknown opcodes raise err.
module pipe4p_alu_core
    import pipe4p_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [3:0]    func,
    output logic [DW-1:0] result,
    output logic          err
);

    always_comb begin
        result = '0;
        err    = 1'b0;
        case (func)
            OP_ADD: result = a + b;
            OP_SUB: result = a - b;
            OP_MUL: result = a * b;
            OP_DIV: begin
                if (b == '0) begin
                    result = '1;
                    err    = 1'b1;
                end else begin
                    result = a / b;
                end
            end
            OP_MOD: begin
                if (b == '0) begin
                    result = '1;
                    err    = 1'b1;
                end else begin
                    result = a % b;
                end
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/pipe4p_alu.sv
`timescale 1ns/1ps
// Four-stage ALU pipeline: operand read with full forwarding, ALU (drives f),
// register-bank writeback, and data-memory store of the result.
module pipe4p_alu
    import pipe4p_pkg::*;
#(
    parameter int  DW   = DW_DEF,
    parameter int  NREG = NREG_DEF,
    parameter int  AW   = AW_DEF,
    localparam int RW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [RW-1:0] rs1,
    input  logic [RW-1:0] rs2,
    input  logic [RW-1:0] rd,
    input  logic [3:0]    func,
    input  logic [AW-1:0] addr,
    input  logic          ld_valid,
    input  logic [RW-1:0] ld_idx,
    input  logic [DW-1:0] ld_data,
    output logic          out_valid,
    output logic [DW-1:0] f,
    output logic          out_err,
    input  logic [RW-1:0] dbg_ridx,
    output logic [DW-1:0] dbg_rdata,
    input  logic [AW-1:0] dbg_maddr,
    output logic [DW-1:0] dbg_mdata
);

    localparam int DEPTH = 1 << AW;

    // Handshake: an instruction on rs1/rs2/rd/func/addr is taken on a rising edge where
    // in_valid && in_ready; in_ready is low during stall or reset and the source must hold.
    logic accept;
    assign in_ready = ~stall & ~rst;
    assign accept   = in_valid & in_ready;

    // ALU stage (S2) registers
    logic          ex_valid_q, ex_valid_d;
    logic [RW-1:0] ex_rd_q, ex_rd_d;
    logic [AW-1:0] ex_addr_q, ex_addr_d;
    logic [3:0]    ex_func_q, ex_func_d;
    logic [DW-1:0] ex_a_q, ex_a_d;
    logic [DW-1:0] ex_b_q, ex_b_d;

    // Writeback stage (S3) registers; f_q doubles as the writeback data
    logic          wb_valid_q, wb_valid_d;
    logic [RW-1:0] wb_rd_q, wb_rd_d;
    logic [AW-1:0] wb_addr_q, wb_addr_d;
    logic [DW-1:0] f_q, f_d;
    logic          err_q, err_d;

    // Store stage (S4) registers
    logic          st_valid_q, st_valid_d;
    logic [AW-1:0] st_addr_q, st_addr_d;
    logic [DW-1:0] st_data_q, st_data_d;

    logic [DW-1:0] regs_q [NREG];
    logic [DW-1:0] regs_d [NREG];
    logic [DW-1:0] mem_q  [DEPTH];
    logic          mem_we;

    logic [DW-1:0] alu_result;
    logic          alu_err;
    logic [DW-1:0] op_a, op_b;

    pipe4p_alu_core #(.DW(DW)) u_core (
        .a      (ex_a_q),
        .b      (ex_b_q),
        .func   (ex_func_q),
        .result (alu_result),
        .err    (alu_err)
    );

    // Later assignments win: the instruction in the ALU is younger than the one in writeback.
    always_comb begin
        op_a = regs_q[rs1];
        op_b = regs_q[rs2];
        if (wb_valid_q && wb_rd_q == rs1) op_a = f_q;
        if (wb_valid_q && wb_rd_q == rs2) op_b = f_q;
        if (ex_valid_q && ex_rd_q == rs1) op_a = alu_result;
        if (ex_valid_q && ex_rd_q == rs2) op_b = alu_result;
    end

    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_rd_d    = ex_rd_q;
        ex_addr_d  = ex_addr_q;
        ex_func_d  = ex_func_q;
        ex_a_d     = ex_a_q;
        ex_b_d     = ex_b_q;
        wb_valid_d = wb_valid_q;
        wb_rd_d    = wb_rd_q;
        wb_addr_d  = wb_addr_q;
        f_d        = f_q;
        err_d      = err_q;
        st_valid_d = st_valid_q;
        st_addr_d  = st_addr_q;
        st_data_d  = st_data_q;
        if (!stall) begin
            ex_valid_d = accept;
            if (accept) begin
                ex_rd_d   = rd;
                ex_addr_d = addr;
                ex_func_d = func;
                ex_a_d    = op_a;
                ex_b_d    = op_b;
            end
            wb_valid_d = ex_valid_q;
            if (ex_valid_q) begin
                wb_rd_d   = ex_rd_q;
                wb_addr_d = ex_addr_q;
                f_d       = alu_result;
                err_d     = alu_err;
            end
            st_valid_d = wb_valid_q;
            if (wb_valid_q) begin
                st_addr_d = wb_addr_q;
                st_data_d = f_q;
            end
        end
    end

    // Writeback is applied after the load port so it wins an index collision.
    always_comb begin
        regs_d = regs_q;
        if (!stall) begin
            if (ld_valid) regs_d[ld_idx] = ld_data;
            if (wb_valid_q) regs_d[wb_rd_q] = f_q;
        end
    end

    assign mem_we = st_valid_q & ~stall & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q <= 1'b0;
            wb_valid_q <= 1'b0;
            st_valid_q <= 1'b0;
            f_q        <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            wb_valid_q <= wb_valid_d;
            st_valid_q <= st_valid_d;
            f_q        <= f_d;
            err_q      <= err_d;
            regs_q     <= regs_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_rd_q   <= ex_rd_d;
            ex_addr_q <= ex_addr_d;
            ex_func_q <= ex_func_d;
            ex_a_q    <= ex_a_d;
            ex_b_q    <= ex_b_d;
            wb_rd_q   <= wb_rd_d;
            wb_addr_q <= wb_addr_d;
            st_addr_q <= st_addr_d;
            st_data_q <= st_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[st_addr_q] <= st_data_q;
    end

    assign out_valid = wb_valid_q;
    assign f         = f_q;
    assign out_err   = err_q;
    assign dbg_rdata = regs_q[dbg_ridx];
    assign dbg_mdata = mem_q[dbg_maddr];

endmodule
